// File: rtl/instr_mem_sync_if.sv
// Fetch / response / program-load bundle for instr_mem_sync.
// The master side issues fetches and loads; the slave side is the memory block.
interface instr_mem_sync_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_misaligned;

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_byte;

  logic              busy;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    output load_en,
    output load_addr,
    output load_byte,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_misaligned,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    input  load_en,
    input  load_addr,
    input  load_byte,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_misaligned,
    output busy
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Byte-addressed instruction memory with a power-up init sweep (word k = k, big-endian),
// single-entry registered fetch response and a byte-wide program-load port.
module instr_mem_sync #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_sync_if.slave      bus
);

  localparam int unsigned BPW    = DATA_W / 8;
  localparam int unsigned MEM_AW = $clog2(DEPTH_BYTES);
  localparam int unsigned WORDS  = DEPTH_BYTES / BPW;
  localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BOFF_W = $clog2(BPW);

  typedef enum logic {StInit, StRun} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_instr;
  logic              r_rsp_mis;
  logic [7:0]        r_mem [DEPTH_BYTES];

  logic [MEM_AW-1:0] w_req_idx;
  logic [MEM_AW-1:0] w_load_idx;
  logic [MEM_AW-1:0] w_init_base;
  logic [DATA_W-1:0] w_init_word;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_misaligned;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_unused;

  // Upper address bits are ignored: storage wraps on the low MEM_AW bits.
  assign w_req_idx    = bus.req_addr[MEM_AW-1:0];
  assign w_load_idx   = bus.load_addr[MEM_AW-1:0];
  assign w_init_base  = MEM_AW'(r_cnt) << BOFF_W;
  assign w_init_word  = DATA_W'(r_cnt);
  assign w_misaligned = |(bus.req_addr & ADDR_W'(BPW - 1));
  assign w_unused     = ^{bus.req_addr, bus.load_addr};

  assign w_req_ready = (r_state == StRun) && (!r_rsp_valid || bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;

  // Byte i of the word (i = 0 is the MSB) comes from req_addr + i, wrapping at the top.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < BPW; i++) begin
      w_rd_data[DATA_W-1-8*i -: 8] = r_mem[w_req_idx + MEM_AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StInit;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_mis   <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WORDS - 1)) begin
            r_state <= StRun;
            r_busy  <= 1'b0;
          end
        end
        StRun: begin
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_rd_data;
            r_rsp_mis   <= w_misaligned;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Fetch reads above see the pre-edge contents, so a same-cycle load is read-before-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == StInit) begin
        for (int unsigned i = 0; i < BPW; i++) begin
          r_mem[w_init_base + MEM_AW'(i)] <= w_init_word[DATA_W-1-8*i -: 8];
        end
      end else if (bus.load_en) begin
        r_mem[w_load_idx] <= bus.load_byte;
      end
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_instr      = r_rsp_instr;
  assign bus.rsp_misaligned = r_rsp_mis;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: default 16-bit/256-byte instance plus a
// 32-bit/64-byte instance, expected values hand-computed from the init pattern.
module tb_instr_mem_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instr_mem_sync_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  instr_mem_sync_if #(.DATA_W(32), .ADDR_W(16)) bus_b ();

  instr_mem_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(256)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  instr_mem_sync #(.DATA_W(32), .ADDR_W(16), .DEPTH_BYTES(64)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int unsigned n;
  logic        rdy_seen;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.rsp_ready = 1'b0;
    bus_a.load_en   = 1'b0; bus_a.load_addr = '0; bus_a.load_byte = '0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.rsp_ready = 1'b0;
    bus_b.load_en   = 1'b0; bus_b.load_addr = '0; bus_b.load_byte = '0;
    step(); step();

    // Reset state
    chk("rst_busy", 32'(bus_a.busy), 32'd1);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst_rsp_instr", 32'(bus_a.rsp_instr), 32'd0);
    chk("rst_rsp_mis", 32'(bus_a.rsp_misaligned), 32'd0);

    // Init sweep length with a fetch held pending; a load at cycle 100 must be ignored
    rst_a = 1'b0;
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = 16'h0006;
    n = 0;
    rdy_seen = 1'b0;
    while (bus_a.busy && n < 300) begin
      if (bus_a.req_ready) rdy_seen = 1'b1;
      bus_a.load_en   = (n == 100);
      bus_a.load_addr = 16'h0002;
      bus_a.load_byte = 8'hEE;
      step();
      n++;
    end
    bus_a.load_en = 1'b0;
    #1;
    chk("init_cycles", n, 32'd128);
    chk("ready_during_init", 32'(rdy_seen), 32'd0);
    chk("ready_after_init", 32'(bus_a.req_ready), 32'd1);
    step();
    chk("fetch06_valid", 32'(bus_a.rsp_valid), 32'd1);
    chk("fetch06_instr", 32'(bus_a.rsp_instr), 32'h0003);
    chk("fetch06_mis", 32'(bus_a.rsp_misaligned), 32'd0);
    chk("hold_req_ready", 32'(bus_a.req_ready), 32'd0);

    // Wrap at the top of memory, then upper address bits ignored
    bus_a.rsp_ready = 1'b1;
    bus_a.req_addr  = 16'h00FF;
    step();
    chk("fetchFF_instr", 32'(bus_a.rsp_instr), 32'h7F00);
    chk("fetchFF_mis", 32'(bus_a.rsp_misaligned), 32'd1);
    bus_a.req_addr = 16'h0105;
    step();
    chk("fetch105_instr", 32'(bus_a.rsp_instr), 32'h0200);
    chk("fetch105_mis", 32'(bus_a.rsp_misaligned), 32'd1);
    bus_a.req_valid = 1'b0;
    step();
    chk("drain_valid", 32'(bus_a.rsp_valid), 32'd0);

    // Back-pressure: 0x00 registered, 0x02 and 0x04 must follow in order
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = 16'h0000;
    step();
    bus_a.req_addr = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
      chk("bp_instr", 32'(bus_a.rsp_instr), 32'h0000);
      chk("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
    end
    bus_a.rsp_ready = 1'b1;
    step();
    chk("bp_second", 32'(bus_a.rsp_instr), 32'h0001);
    bus_a.req_addr = 16'h0004;
    step();
    chk("bp_third", 32'(bus_a.rsp_instr), 32'h0002);
    chk("bp_third_valid", 32'(bus_a.rsp_valid), 32'd1);
    bus_a.req_valid = 1'b0;
    step();
    chk("bp_drain", 32'(bus_a.rsp_valid), 32'd0);

    // Load and fetch of the same byte in one cycle: read-before-write
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = 16'h0010;
    bus_a.load_en   = 1'b1;
    bus_a.load_addr = 16'h0011;
    bus_a.load_byte = 8'hAB;
    step();
    chk("rbw_old", 32'(bus_a.rsp_instr), 32'h0008);
    bus_a.load_en = 1'b0;
    step();
    chk("rbw_new", 32'(bus_a.rsp_instr), 32'h00AB);

    // A held response is not disturbed by a later load to its source bytes
    bus_a.rsp_ready = 1'b0;
    bus_a.load_en   = 1'b1;
    bus_a.load_byte = 8'hCD;
    step();
    chk("held_after_load", 32'(bus_a.rsp_instr), 32'h00AB);
    bus_a.load_en   = 1'b0;
    bus_a.rsp_ready = 1'b1;
    step();
    chk("refetch_loaded", 32'(bus_a.rsp_instr), 32'h00CD);

    // Reset in RUN with a pending response; load/fetch under reset ignored
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 1'b1;
    bus_a.load_en   = 1'b1;
    bus_a.load_addr = 16'h0020;
    bus_a.load_byte = 8'h55;
    rst_a = 1'b1;
    step();
    chk("rrst_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rrst_instr", 32'(bus_a.rsp_instr), 32'd0);
    chk("rrst_busy", 32'(bus_a.busy), 32'd1);
    rst_a = 1'b0;
    bus_a.load_en   = 1'b0;
    bus_a.req_valid = 1'b0;

    // Reset again 60 cycles into the sweep; full sweep must restart
    for (int i = 0; i < 60; i++) step();
    chk("mid_init_busy", 32'(bus_a.busy), 32'd1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    n = 0;
    while (bus_a.busy && n < 300) begin
      step();
      n++;
    end
    chk("reinit_cycles", n, 32'd128);
    bus_a.rsp_ready = 1'b1;
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = 16'h0010;
    step();
    chk("reinit_overwrite", 32'(bus_a.rsp_instr), 32'h0008);
    bus_a.req_addr = 16'h0020;
    step();
    chk("reinit_word16", 32'(bus_a.rsp_instr), 32'h0010);
    bus_a.req_valid = 1'b0;

    // 32-bit / 64-byte instance
    chk("b_rst_busy", 32'(bus_b.busy), 32'd1);
    rst_b = 1'b0;
    bus_b.req_valid = 1'b1;
    bus_b.req_addr  = 16'h0008;
    bus_b.rsp_ready = 1'b1;
    n = 0;
    rdy_seen = 1'b0;
    while (bus_b.busy && n < 300) begin
      if (bus_b.req_ready) rdy_seen = 1'b1;
      step();
      n++;
    end
    chk("b_init_cycles", n, 32'd16);
    chk("b_ready_during_init", 32'(rdy_seen), 32'd0);
    step();
    chk("b_fetch08", bus_b.rsp_instr, 32'h0000_0002);
    chk("b_fetch08_mis", 32'(bus_b.rsp_misaligned), 32'd0);
    bus_b.req_addr = 16'h003E;
    step();
    chk("b_fetch3E", bus_b.rsp_instr, 32'h000F_0000);
    chk("b_fetch3E_mis", 32'(bus_b.rsp_misaligned), 32'd1);
    bus_b.req_valid = 1'b0;
    step();
    chk("b_drain", 32'(bus_b.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
